fpdiv_ctrl: RTL and testbench
=============================

FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

Interface
REQ-001 SHALL have parameter ITERS, default 5, the number of Goldschmidt refinement iterations after the initial-approximation pair (legal 1..7).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous, active-low (0 = reset).
REQ-004 SHALL have port start, input, 1 bit, the operation request, sampled only in IDLE.
REQ-005 SHALL have port rm_in, input, 1 bit, the rounding mode, latched on accepted start.
REQ-006 SHALL have port num_iter, input, 3 bits, the run-time iteration count; present only when FPDIV_CTRL_ITERCFG_EN is defined.
REQ-007 SHALL have port rm, output, 1 bit, the latched rounding mode to the fpdiv datapath.
REQ-008 SHALL have port sel_mux3, output, 2 bits, the multiplier-operand select (00 IA, 01 C register, 10 remainder).
REQ-009 SHALL have port sel_mux4, output, 2 bits, the multiplier-input select (00 num-IA, 01 denom-IA, 10 num-iter, 11 denom-iter).
REQ-010 SHALL have ports en_a, en_b and en_rem, each output, 1 bit, the A-, B- and remainder-register load enables.
REQ-011 SHALL have port busy, output, 1 bit, high while a division is being sequenced.
REQ-012 SHALL have port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-013 SHALL implement the states IDLE, IA_N, IA_D, IT_N, IT_D, REM and DONE, with all outputs registered (Moore).
REQ-014 SHALL move IDLE->IA_N on start=1 and latch rm_in and the iteration count on that edge; start is ignored in every other state.
REQ-015 SHALL drive in IA_N: sel_mux4=00, sel_mux3=00, en_a=1, en_b=0, en_rem=0.
REQ-016 SHALL drive in IA_D: sel_mux4=01, sel_mux3=00, en_b=1, and all other enables 0.
REQ-017 SHALL drive in IT_N: sel_mux4=10, sel_mux3=01, en_a=1.
REQ-018 SHALL drive in IT_D: sel_mux4=11, sel_mux3=01, en_b=1.
REQ-019 SHALL sequence IA_D->IT_N->IT_D, decrementing a 3-bit count in IT_D, and go IT_D->REM when count==1, otherwise IT_D->IT_N.
REQ-020 SHALL drive in REM: sel_mux4=10, sel_mux3=10, en_rem=1, en_a=0, en_b=0.
REQ-021 SHALL pass through DONE for exactly one cycle with done=1, busy=0 and all enables 0, then return to IDLE.
REQ-022 SHALL hold sel_mux3 and sel_mux4 at their last values in DONE and IDLE, so the remainder path stays selected for result readout.
REQ-023 SHALL hold busy=1 in IA_N through REM and 0 otherwise.
REQ-024 SHALL, for a start accepted at edge k, enter REM at edge k+2+2*N and DONE at edge k+3+2*N (N = iteration count), giving 14 cycles total at N=5.
REQ-025 SHALL accept a start asserted in the cycle after done (back-to-back operation) with no idle penalty beyond one IDLE cycle.

Reset
REQ-026 SHALL, when reset=0 at a rising edge, force state IDLE, sel_mux3=00, sel_mux4=00, en_a=en_b=en_rem=0, rm=0, busy=0, done=0 and the count to 0.
REQ-027 SHALL abort any operation in progress when reset occurs mid-operation, produce no done pulse, and give reset priority over start.

Configuration
REQ-028 SHALL, when FPDIV_CTRL_ITERCFG_EN is defined, latch num_iter at start as N, with num_iter=0 treated as 1.
REQ-029 SHALL, when FPDIV_CTRL_ITERCFG_EN is undefined, omit the num_iter port and use N=ITERS.

Verification
REQ-030 SHALL cover: reset=0 for 3 cycles -> all outputs 0, state IDLE.
REQ-031 SHALL cover: start=1 one cycle with rm_in=1, N=5 -> per-cycle {sel_mux4,en_a,en_b} = 00/1/0, 01/0/1, then five pairs of 10/1/0 and 11/0/1; REM (en_rem=1, sel_mux3=10) at cycle 13; done=1 at cycle 14; rm=1 throughout.
REQ-032 SHALL cover: start pulsed again at cycles 4 and 10 of a running operation -> ignored, and the sequence is identical to REQ-031.
REQ-033 SHALL cover: reset=0 at cycle 6 of an operation -> all outputs 0 after that edge, no done pulse, and a fresh start afterwards behaves as REQ-031.
REQ-034 SHALL cover: start held high continuously -> done pulses every 15 cycles.
REQ-035 SHALL cover, with FPDIV_CTRL_ITERCFG_EN defined: num_iter=0 -> REM at cycle 5, done at cycle 6; num_iter=7 -> REM at cycle 17, done at cycle 18.

Source files
------------

// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl -- sequencer for a Goldschmidt floating-point divider datapath.
//
// Walks the datapath through the initial-approximation pair (IA_N, IA_D),
// N refinement pairs (IT_N, IT_D), the remainder step (REM) and a one-cycle
// DONE pulse. All outputs come straight from flops (Moore).
//
// Build option:
//   FPDIV_CTRL_ITERCFG_EN  -- adds the num_iter port; N is latched from it
//                             at start (0 is treated as 1). Without it,
//                             N is the ITERS parameter.
module fpdiv_ctrl #(
    parameter int ITERS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rm_in,
`ifdef FPDIV_CTRL_ITERCFG_EN
    input  logic [2:0] num_iter,
`endif
    output logic       rm,
    output logic [1:0] sel_mux3,
    output logic [1:0] sel_mux4,
    output logic       en_a,
    output logic       en_b,
    output logic       en_rem,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IA_N,
        S_IA_D,
        S_IT_N,
        S_IT_D,
        S_REM,
        S_DONE
    } state_t;

    // Operand select codes for the multiplier input muxes.
    localparam logic [1:0] M3_IA   = 2'b00;
    localparam logic [1:0] M3_CREG = 2'b01;
    localparam logic [1:0] M3_REM  = 2'b10;

    localparam logic [1:0] M4_NUM_IA   = 2'b00;
    localparam logic [1:0] M4_DEN_IA   = 2'b01;
    localparam logic [1:0] M4_NUM_ITER = 2'b10;
    localparam logic [1:0] M4_DEN_ITER = 2'b11;

    // Out-of-range ITERS is clamped into 1..7 so the 3-bit counter
    // always terminates.
    localparam logic [2:0] ITERS_N = (ITERS < 1) ? 3'd1 :
                                     (ITERS > 7) ? 3'd7 : 3'(ITERS);

    // Registered output bundle; one struct keeps the next-value logic
    // and the flop bank in step.
    typedef struct packed {
        logic [1:0] sel_mux3;
        logic [1:0] sel_mux4;
        logic       en_a;
        logic       en_b;
        logic       en_rem;
        logic       busy;
        logic       done;
    } ctrl_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] count;
    logic [2:0] count_next;
    logic       rm_next;
    ctrl_t      ctrl;
    ctrl_t      ctrl_next;
    logic [2:0] start_count;

    // Iteration count loaded into the counter when a start is accepted.
`ifdef FPDIV_CTRL_ITERCFG_EN
    assign start_count = (num_iter == 3'd0) ? 3'd1 : num_iter;
`else
    assign start_count = ITERS_N;
`endif

    // Next-state, counter and latched-mode logic, plus next output values
    // decoded from the state being entered so the outputs can be registered.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise a latch is inferred.
        state_next = state;
        count_next = count;
        rm_next    = rm;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_IA_N;
                    count_next = start_count;
                    rm_next    = rm_in;
                end
            end
            S_IA_N: state_next = S_IA_D;
            S_IA_D: state_next = S_IT_N;
            S_IT_N: state_next = S_IT_D;
            S_IT_D: begin
                count_next = count - 3'd1;
                state_next = (count == 3'd1) ? S_REM : S_IT_N;
            end
            S_REM:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Mux selects hold by default so DONE/IDLE keep the remainder path
        // selected for readout; enables and status default low.
        ctrl_next        = ctrl;
        ctrl_next.en_a   = 1'b0;
        ctrl_next.en_b   = 1'b0;
        ctrl_next.en_rem = 1'b0;
        ctrl_next.busy   = 1'b0;
        ctrl_next.done   = 1'b0;

        unique case (state_next)
            S_IA_N: begin
                ctrl_next.sel_mux4 = M4_NUM_IA;
                ctrl_next.sel_mux3 = M3_IA;
                ctrl_next.en_a     = 1'b1;
                ctrl_next.busy     = 1'b1;
            end
            S_IA_D: begin
                ctrl_next.sel_mux4 = M4_DEN_IA;
                ctrl_next.sel_mux3 = M3_IA;
                ctrl_next.en_b     = 1'b1;
                ctrl_next.busy     = 1'b1;
            end
            S_IT_N: begin
                ctrl_next.sel_mux4 = M4_NUM_ITER;
                ctrl_next.sel_mux3 = M3_CREG;
                ctrl_next.en_a     = 1'b1;
                ctrl_next.busy     = 1'b1;
            end
            S_IT_D: begin
                ctrl_next.sel_mux4 = M4_DEN_ITER;
                ctrl_next.sel_mux3 = M3_CREG;
                ctrl_next.en_b     = 1'b1;
                ctrl_next.busy     = 1'b1;
            end
            S_REM: begin
                ctrl_next.sel_mux4 = M4_NUM_ITER;
                ctrl_next.sel_mux3 = M3_REM;
                ctrl_next.en_rem   = 1'b1;
                ctrl_next.busy     = 1'b1;
            end
            S_DONE: begin
                ctrl_next.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, counter, rounding mode and output flops; synchronous reset
    // aborts any operation in progress and wins over start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state <= S_IDLE;
            count <= 3'd0;
            rm    <= 1'b0;
            ctrl  <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            rm    <= rm_next;
            ctrl  <= ctrl_next;
        end
    end

    assign sel_mux3 = ctrl.sel_mux3;
    assign sel_mux4 = ctrl.sel_mux4;
    assign en_a     = ctrl.en_a;
    assign en_b     = ctrl.en_b;
    assign en_rem   = ctrl.en_rem;
    assign busy     = ctrl.busy;
    assign done     = ctrl.done;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb_fpdiv_ctrl -- directed, table-driven bench for fpdiv_ctrl.
// Cycle c of an operation is the cycle after the (c-1)th rising edge
// following the edge that accepted start; outputs are sampled on the
// falling edge in the middle of each cycle.
module tb_fpdiv_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       rm_in = 1'b0;
`ifdef FPDIV_CTRL_ITERCFG_EN
    logic [2:0] num_iter = 3'd0;
`endif
    logic       rm;
    logic [1:0] sel_mux3;
    logic [1:0] sel_mux4;
    logic       en_a;
    logic       en_b;
    logic       en_rem;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fpdiv_ctrl #(.ITERS(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rm_in    (rm_in),
`ifdef FPDIV_CTRL_ITERCFG_EN
        .num_iter (num_iter),
`endif
        .rm       (rm),
        .sel_mux3 (sel_mux3),
        .sel_mux4 (sel_mux4),
        .en_a     (en_a),
        .en_b     (en_b),
        .en_rem   (en_rem),
        .busy     (busy),
        .done     (done)
    );

    // {sel_mux4, sel_mux3, en_a, en_b, en_rem, busy, done}
    typedef struct packed {
        logic [1:0] s4;
        logic [1:0] s3;
        logic       a;
        logic       b;
        logic       r;
        logic       bsy;
        logic       dn;
    } vec_t;

    localparam vec_t V_ZERO = '0;
    localparam vec_t V_IA_N = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam vec_t V_IA_D = '{2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam vec_t V_IT_N = '{2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam vec_t V_IT_D = '{2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam vec_t V_REM  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam vec_t V_DONE = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam vec_t V_HOLD = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Expected per-cycle outputs for N=5, cycles 1..15 (15 = IDLE after DONE).
    vec_t exp_tab [1:15];

    function automatic vec_t actual_vec();
        return '{sel_mux4, sel_mux3, en_a, en_b, en_rem, busy, done};
    endfunction

    // Expected outputs at cycle c for any iteration count n.
    function automatic vec_t model(int c, int n);
        if (c == 1)          return V_IA_N;
        if (c == 2)          return V_IA_D;
        if (c <= 2 * n + 2)  return (c % 2 == 1) ? V_IT_N : V_IT_D;
        if (c == 2 * n + 3)  return V_REM;
        if (c == 2 * n + 4)  return V_DONE;
        return V_HOLD;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle; on return we are mid-cycle 1. Inputs are
    // flipped afterwards to prove they were latched on the accepting edge.
    task automatic do_start(input logic r, input logic [2:0] n_cfg);
        @(negedge clk);
        start = 1'b1;
        rm_in = r;
`ifdef FPDIV_CTRL_ITERCFG_EN
        num_iter = n_cfg;
`else
        if (n_cfg != 3'd5) $display("note: iteration count fixed at 5");
`endif
        @(negedge clk);
        start = 1'b0;
        rm_in = ~r;
`ifdef FPDIV_CTRL_ITERCFG_EN
        num_iter = ~n_cfg;
`endif
    endtask

    // Check cycles 1..2n+5; optionally pulse start at cycles 4 and 10.
    task automatic check_seq(input int n, input logic rm_exp, input bit inject,
                             input string tag);
        vec_t e;
        for (int c = 1; c <= 2 * n + 5; c++) begin
            if (c > 1) @(negedge clk);
            start = inject && (c == 4 || c == 10);
            e = (n == 5) ? exp_tab[c] : model(c, n);
            check($sformatf("%s outs cyc%0d", tag, c), 32'(actual_vec()), 32'(e));
            check($sformatf("%s rm cyc%0d", tag, c), 32'(rm), 32'(rm_exp));
        end
        start = 1'b0;
    endtask

    initial begin : main
        int done_cyc [3];
        int found;
        int pulses;

        exp_tab[1]  = V_IA_N;
        exp_tab[2]  = V_IA_D;
        exp_tab[3]  = V_IT_N;  exp_tab[4]  = V_IT_D;
        exp_tab[5]  = V_IT_N;  exp_tab[6]  = V_IT_D;
        exp_tab[7]  = V_IT_N;  exp_tab[8]  = V_IT_D;
        exp_tab[9]  = V_IT_N;  exp_tab[10] = V_IT_D;
        exp_tab[11] = V_IT_N;  exp_tab[12] = V_IT_D;
        exp_tab[13] = V_REM;
        exp_tab[14] = V_DONE;
        exp_tab[15] = V_HOLD;

        // Reset for 3 cycles with start and rm_in high: reset has priority.
        reset = 1'b0;
        start = 1'b1;
        rm_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset outs", 32'(actual_vec()), 32'(V_ZERO));
        check("reset rm", 32'(rm), 32'd0);
        start = 1'b0;
        rm_in = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle outs", 32'(actual_vec()), 32'(V_ZERO));

        // Basic N=5 run with rm_in=1.
        do_start(1'b1, 3'd5);
        check_seq(5, 1'b1, 1'b0, "basic");

        // Start pulses at cycles 4 and 10 are ignored.
        do_start(1'b1, 3'd5);
        check_seq(5, 1'b1, 1'b1, "ignore");

        // rm_in=0 is latched and held.
        do_start(1'b0, 3'd5);
        check_seq(5, 1'b0, 1'b0, "rm0");

        // Reset during cycle 6 aborts: outputs zero, no done pulse.
        do_start(1'b1, 3'd5);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort outs", 32'(actual_vec()), 32'(V_ZERO));
        check("abort rm", 32'(rm), 32'd0);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort no done", 32'(pulses), 32'd0);
        do_start(1'b1, 3'd5);
        check_seq(5, 1'b1, 1'b0, "after abort");

        // Start held high: done at cycles 14, 29, 44.
        @(negedge clk);
        start = 1'b1;
        rm_in = 1'b1;
`ifdef FPDIV_CTRL_ITERCFG_EN
        num_iter = 3'd5;
`endif
        found = 0;
        done_cyc = '{-1, -1, -1};
        for (int cyc = 1; cyc <= 60 && found < 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_cyc[found] = cyc;
                found++;
            end
        end
        start = 1'b0;
        check("b2b done1", 32'(done_cyc[0]), 32'd14);
        check("b2b done2", 32'(done_cyc[1]), 32'd29);
        check("b2b done3", 32'(done_cyc[2]), 32'd44);
        repeat (3) @(negedge clk);
        check("b2b idle", 32'(actual_vec()), 32'(V_HOLD));

`ifdef FPDIV_CTRL_ITERCFG_EN
        // num_iter=0 behaves as 1; 7 is the maximum; 3 a mid value.
        do_start(1'b1, 3'd0);
        check_seq(1, 1'b1, 1'b0, "iter0");
        do_start(1'b1, 3'd7);
        check_seq(7, 1'b1, 1'b0, "iter7");
        do_start(1'b0, 3'd3);
        check_seq(3, 1'b0, 1'b0, "iter3");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
